// File: rtl/mii_pkg.sv
// Shared types and constants for the MII half-duplex transmit sequencer.
// Holds the FSM state encoding, default timing constants, the jam nibble
// value and the backoff LFSR definition.
package mii_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IFG,
    ST_XMIT,
    ST_JAM,
    ST_BACKOFF
  } state_t;

  localparam logic [3:0] JAM_NIBBLE = 4'h5;

  localparam int unsigned SLOT_NIBBLES_DEF  = 128;
  localparam int unsigned IFG_NIBBLES_DEF   = 24;
  localparam int unsigned JAM_NIBBLES_DEF   = 8;
  localparam int unsigned MAX_ATTEMPTS_DEF  = 16;
  localparam int unsigned BACKOFF_LIMIT_DEF = 10;

  localparam int unsigned ATT_W  = 5;   // attempts counter width
  localparam int unsigned R_W    = 10;  // backoff multiplier width
  localparam int unsigned LFSR_W = 16;

  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  // x^16 + x^14 + x^13 + x^11 + 1, left-shifting Fibonacci form
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mii_tx_ctrl_if.sv
// Client/transmitter handshake bundle for mii_tx_ctrl.
// master: requester side (tx_req, tx_done in; status pulses observed).
// slave : the sequencer (drives tx_start/jam/abort/ok/fail/late, attempts).
interface mii_tx_ctrl_if;
  import mii_pkg::*;

  logic             tx_req;
  logic             tx_done;
  logic             tx_start;
  logic             tx_jam;
  logic             tx_abort;
  logic             tx_ok;
  logic             tx_fail;
  logic             tx_late;
  logic [ATT_W-1:0] attempts;

  modport master (
    output tx_req, tx_done,
    input  tx_start, tx_jam, tx_abort, tx_ok, tx_fail, tx_late, attempts
  );

  modport slave (
    input  tx_req, tx_done,
    output tx_start, tx_jam, tx_abort, tx_ok, tx_fail, tx_late, attempts
  );

endinterface

// File: rtl/mii_backoff_lfsr.sv
// Free-running 16-bit LFSR with truncated-exponent mask for backoff.
// Ports: txc, rst_n (sync, active-low); attempts = collision count used for
// the exponent; sample = strobe capturing r; r = registered slot multiplier.
module mii_backoff_lfsr
  import mii_pkg::*;
#(
  parameter int unsigned BACKOFF_LIMIT = BACKOFF_LIMIT_DEF
) (
  input  logic             txc,
  input  logic             rst_n,
  input  logic [ATT_W-1:0] attempts,
  input  logic             sample,
  output logic [R_W-1:0]   r
);

  localparam int unsigned K_MAX = (BACKOFF_LIMIT < R_W) ? BACKOFF_LIMIT : R_W;
  localparam int unsigned K_W   = 4;

  logic [LFSR_W-1:0] lfsr;
  logic [K_W-1:0]    k_c;
  logic [R_W:0]      one_sh_c;
  logic [R_W-1:0]    mask_c;

  // k = min(attempts, limit); mask = (1<<k)-1
  always_comb begin
    k_c      = (attempts < ATT_W'(K_MAX)) ? K_W'(attempts) : K_W'(K_MAX);
    one_sh_c = (R_W+1)'(1) << k_c;
    mask_c   = R_W'(one_sh_c - (R_W+1)'(1));
  end

  always_ff @(posedge txc) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
      r    <= '0;
    end else begin
      lfsr <= lfsr_step(lfsr);
      if (sample) r <= lfsr[R_W-1:0] & mask_c;
    end
  end

endmodule

// File: rtl/mii_tx_ctrl.sv
// Half-duplex CSMA/CD transmit sequencer: carrier deferral, inter-frame gap,
// collision jam, truncated binary exponential backoff and retry.
// Ports: txc clock; rst_n sync active-low reset; crs/col async PHY inputs;
// bus (slave modport) carries the client/transmitter handshake.
module mii_tx_ctrl
  import mii_pkg::*;
#(
  parameter int unsigned SLOT_NIBBLES  = SLOT_NIBBLES_DEF,
  parameter int unsigned IFG_NIBBLES   = IFG_NIBBLES_DEF,
  parameter int unsigned JAM_NIBBLES   = JAM_NIBBLES_DEF,
  parameter int unsigned MAX_ATTEMPTS  = MAX_ATTEMPTS_DEF,
  parameter int unsigned BACKOFF_LIMIT = BACKOFF_LIMIT_DEF
) (
  input  logic txc,
  input  logic rst_n,
  input  logic crs,
  input  logic col,
  mii_tx_ctrl_if.slave bus
);

  localparam int unsigned IFG_W  = $clog2(IFG_NIBBLES + 1);
  localparam int unsigned SLOT_W = $clog2(SLOT_NIBBLES + 1);
  localparam int unsigned JAM_W  = $clog2(JAM_NIBBLES + 1);
  localparam int unsigned BO_W   = R_W + SLOT_W;

  state_t            state, state_d;
  logic [IFG_W-1:0]  ifg_cnt, ifg_d;
  logic [SLOT_W-1:0] slot_cnt, slot_d;
  logic [JAM_W-1:0]  jam_cnt, jam_d;
  logic [BO_W-1:0]   bo_cnt, bo_d, bo_last_c;
  logic              late, late_d;
  logic [ATT_W-1:0]  attempts_q, att_d;
  logic              crs_m, crs_s, col_m, col_s;
  logic              start_q, jam_q, abort_q, ok_q, fail_q, late_p_q;
  logic              start_d, abort_d, ok_d, fail_d, late_p_d;
  logic              sample_c;
  logic [R_W-1:0]    r;

  mii_backoff_lfsr #(.BACKOFF_LIMIT(BACKOFF_LIMIT)) u_lfsr (
    .txc      (txc),
    .rst_n    (rst_n),
    .attempts (att_d),
    .sample   (sample_c),
    .r        (r)
  );

  // Last BACKOFF cycle index: r slots, or a single cycle when r is zero
  always_comb begin
    bo_last_c = (r == '0) ? '0
              : BO_W'(BO_W'(r) * BO_W'(SLOT_NIBBLES) - BO_W'(1));
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state;
    ifg_d    = ifg_cnt;
    slot_d   = slot_cnt;
    jam_d    = jam_cnt;
    bo_d     = bo_cnt;
    late_d   = late;
    att_d    = attempts_q;
    start_d  = 1'b0;
    abort_d  = 1'b0;
    ok_d     = 1'b0;
    fail_d   = 1'b0;
    late_p_d = 1'b0;
    sample_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.tx_req) begin
          att_d   = '0;
          ifg_d   = '0;
          late_d  = 1'b0;
          state_d = ST_IFG;
        end
      end
      ST_IFG: begin
        if (crs_s) begin
          ifg_d = '0;
        end else if (ifg_cnt == IFG_W'(IFG_NIBBLES)) begin
          start_d = 1'b1;
          slot_d  = '0;
          state_d = ST_XMIT;
        end else begin
          ifg_d = ifg_cnt + IFG_W'(1);
        end
      end
      ST_XMIT: begin
        if (slot_cnt != SLOT_W'(SLOT_NIBBLES)) slot_d = slot_cnt + SLOT_W'(1);
        // frame completion takes priority over a coincident collision
        if (bus.tx_done) begin
          ok_d    = 1'b1;
          state_d = ST_IDLE;
        end else if (col_s) begin
          late_d  = (slot_cnt == SLOT_W'(SLOT_NIBBLES));
          jam_d   = '0;
          state_d = ST_JAM;
        end
      end
      ST_JAM: begin
        if (jam_cnt == JAM_W'(JAM_NIBBLES - 1)) begin
          abort_d = 1'b1;
          att_d   = attempts_q + ATT_W'(1);
          if (late) begin
            fail_d   = 1'b1;
            late_p_d = 1'b1;
            state_d  = ST_IDLE;
          end else if (att_d == ATT_W'(MAX_ATTEMPTS)) begin
            fail_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            sample_c = 1'b1;
            bo_d     = '0;
            state_d  = ST_BACKOFF;
          end
        end else begin
          jam_d = jam_cnt + JAM_W'(1);
        end
      end
      ST_BACKOFF: begin
        if (bo_cnt == bo_last_c) begin
          ifg_d   = '0;
          state_d = ST_IFG;
        end else begin
          bo_d = bo_cnt + BO_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters, synchronizers and registered outputs
  always_ff @(posedge txc) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ifg_cnt    <= '0;
      slot_cnt   <= '0;
      jam_cnt    <= '0;
      bo_cnt     <= '0;
      late       <= 1'b0;
      attempts_q <= '0;
      crs_m      <= 1'b0;
      crs_s      <= 1'b0;
      col_m      <= 1'b0;
      col_s      <= 1'b0;
      start_q    <= 1'b0;
      jam_q      <= 1'b0;
      abort_q    <= 1'b0;
      ok_q       <= 1'b0;
      fail_q     <= 1'b0;
      late_p_q   <= 1'b0;
    end else begin
      state      <= state_d;
      ifg_cnt    <= ifg_d;
      slot_cnt   <= slot_d;
      jam_cnt    <= jam_d;
      bo_cnt     <= bo_d;
      late       <= late_d;
      attempts_q <= att_d;
      crs_m      <= crs;
      crs_s      <= crs_m;
      col_m      <= col;
      col_s      <= col_m;
      start_q    <= start_d;
      jam_q      <= (state_d == ST_JAM);
      abort_q    <= abort_d;
      ok_q       <= ok_d;
      fail_q     <= fail_d;
      late_p_q   <= late_p_d;
    end
  end

  assign bus.tx_start = start_q;
  assign bus.tx_jam   = jam_q;
  assign bus.tx_abort = abort_q;
  assign bus.tx_ok    = ok_q;
  assign bus.tx_fail  = fail_q;
  assign bus.tx_late  = late_p_q;
  assign bus.attempts = attempts_q;

endmodule

// File: tb/tb_mii_tx_ctrl.sv
// Directed bench for mii_tx_ctrl: clean send, deferral, collision/backoff,
// excess collisions, late collision, tx_done priority, reset mid-jam.
module tb_mii_tx_ctrl;
  import mii_pkg::*;

  localparam int SLOT = 128;
  localparam int IFG  = 24;
  localparam int JAM  = 8;
  localparam int MAXA = 16;
  localparam int BLIM = 3;

  logic txc   = 1'b0;
  logic rst_n = 1'b0;
  logic crs   = 1'b0;
  logic col   = 1'b0;

  mii_tx_ctrl_if bus ();

  mii_tx_ctrl #(
    .SLOT_NIBBLES  (SLOT),
    .IFG_NIBBLES   (IFG),
    .JAM_NIBBLES   (JAM),
    .MAX_ATTEMPTS  (MAXA),
    .BACKOFF_LIMIT (BLIM)
  ) dut (
    .txc   (txc),
    .rst_n (rst_n),
    .crs   (crs),
    .col   (col),
    .bus   (bus)
  );

  always #5 txc = ~txc;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference LFSR: x^16+x^14+x^13+x^11+1, seed ACE1, shifts left
  logic [15:0] m_lfsr;
  logic [15:0] lfsr_prev;
  always @(posedge txc) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  // Advance one edge; afterwards we sit 1 time unit past edge number cyc
  task automatic tick();
    lfsr_prev = m_lfsr;
    @(posedge txc);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_start(input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (bus.tx_start === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_abort(input int bound, output int at, output int first_jam, output int njam);
    at = -1;
    first_jam = -1;
    njam = 0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (bus.tx_jam === 1'b1) begin
        if (first_jam < 0) first_jam = cyc;
        njam++;
      end
      if (bus.tx_abort === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  function automatic int backoff_gap(input int att, input logic [15:0] l);
    int k, r;
    k = (att < BLIM) ? att : BLIM;
    r = int'(l[9:0]) & ((1 << k) - 1);
    return (r == 0) ? 1 : r * SLOT;
  endfunction

  task automatic test_reset();
    logic [10:0] outs;
    rst_n = 1'b0;
    crs = 1'b0;
    col = 1'b0;
    bus.tx_req = 1'b1;
    bus.tx_done = 1'b0;
    tick();
    tick();
    tick();
    outs = {bus.tx_start, bus.tx_jam, bus.tx_abort, bus.tx_ok, bus.tx_fail, bus.tx_late, bus.attempts};
    total++;
    if (outs !== 11'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %b want %b", outs, 11'd0);
    end
    bus.tx_req = 1'b0;
    rst_n = 1'b1;
    repeat (30) tick();
    total++;
    if (bus.tx_start !== 1'b0) begin
      bad++;
      $display("FAIL idle_no_start: got %b want 0", bus.tx_start);
    end
  endtask

  task automatic test_clean_send();
    int base, at;
    do_reset();
    bus.tx_req = 1'b1;
    base = cyc + 1;
    wait_start(40, at);
    total++;
    if (at !== base + 25) begin
      bad++;
      $display("FAIL clean_start: got cycle %0d want %0d", at - base, 25);
    end
    tick();
    total++;
    if (bus.tx_start !== 1'b0) begin
      bad++;
      $display("FAIL clean_start_pulse: got %b want 0", bus.tx_start);
    end
    while (cyc < base + 100) tick();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    total++;
    if (bus.tx_ok !== 1'b1 || cyc != base + 101) begin
      bad++;
      $display("FAIL clean_ok: got ok=%b at %0d want 1 at 101", bus.tx_ok, cyc - base);
    end
    bus.tx_req = 1'b0;
    total++;
    if (bus.attempts !== 5'd0 || bus.tx_fail !== 1'b0) begin
      bad++;
      $display("FAIL clean_status: got att=%0d fail=%b want 0 0", bus.attempts, bus.tx_fail);
    end
    tick();
    total++;
    if (bus.tx_ok !== 1'b0) begin
      bad++;
      $display("FAIL clean_ok_pulse: got %b want 0", bus.tx_ok);
    end
  endtask

  task automatic test_deferral();
    int base, at;
    do_reset();
    bus.tx_req = 1'b1;
    base = cyc + 1;
    at = -1;
    // carrier on the pin for edges 9..13 is seen by the FSM on edges 11..15
    for (int i = 0; i < 60; i++) begin
      tick();
      if (cyc == base + 8)  crs = 1'b1;
      if (cyc == base + 13) crs = 1'b0;
      if (bus.tx_start === 1'b1) begin
        at = cyc;
        break;
      end
    end
    crs = 1'b0;
    total++;
    if (at !== base + 40) begin
      bad++;
      $display("FAIL defer_start: got cycle %0d want %0d", at - base, 40);
    end
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    total++;
    if (bus.tx_ok !== 1'b1) begin
      bad++;
      $display("FAIL defer_ok: got %b want 1", bus.tx_ok);
    end
    bus.tx_req = 1'b0;
    tick();
  endtask

  task automatic test_collision();
    int t, at, ab, fj, nj, exp_at;
    do_reset();
    bus.tx_req = 1'b1;
    wait_start(40, t);
    while (cyc < t + 20) tick();
    col = 1'b1;
    tick();
    col = 1'b0;
    wait_abort(40, ab, fj, nj);
    total++;
    if (fj !== t + 23 || nj !== JAM) begin
      bad++;
      $display("FAIL coll_jam: got first=%0d len=%0d want first=%0d len=%0d", fj - t, nj, 23, JAM);
    end
    total++;
    if (ab !== t + 31 || bus.tx_jam !== 1'b0 || bus.attempts !== 5'd1 || bus.tx_fail !== 1'b0) begin
      bad++;
      $display("FAIL coll_abort: got at=%0d jam=%b att=%0d fail=%b want at=31 jam=0 att=1 fail=0",
               ab - t, bus.tx_jam, bus.attempts, bus.tx_fail);
    end
    exp_at = ab + backoff_gap(1, lfsr_prev) + IFG + 1;
    wait_start(exp_at - cyc + 4, at);
    total++;
    if (at !== exp_at) begin
      bad++;
      $display("FAIL coll_retry: got cycle %0d want %0d", at, exp_at);
    end
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    bus.tx_req = 1'b0;
    total++;
    if (bus.tx_ok !== 1'b1 || bus.attempts !== 5'd1) begin
      bad++;
      $display("FAIL coll_ok: got ok=%b att=%0d want 1 1", bus.tx_ok, bus.attempts);
    end
    repeat (3) tick();
    total++;
    if (bus.attempts !== 5'd1) begin
      bad++;
      $display("FAIL coll_att_hold: got %0d want 1", bus.attempts);
    end
  endtask

  task automatic test_excess();
    int at, exp_at, ab, fj, nj, nstart;
    do_reset();
    bus.tx_req = 1'b1;
    exp_at = cyc + 1 + IFG + 1;
    for (int a = 1; a <= MAXA; a++) begin
      wait_start(exp_at - cyc + 4, at);
      total++;
      if (at !== exp_at) begin
        bad++;
        $display("FAIL excess_start%0d: got cycle %0d want %0d", a, at, exp_at);
        break;
      end
      repeat (5) tick();
      col = 1'b1;
      tick();
      col = 1'b0;
      wait_abort(40, ab, fj, nj);
      total++;
      if (bus.attempts !== 5'(a) || nj !== JAM) begin
        bad++;
        $display("FAIL excess_att%0d: got att=%0d jam=%0d want att=%0d jam=%0d", a, bus.attempts, nj, a, JAM);
      end
      if (a < MAXA) begin
        total++;
        if (bus.tx_fail !== 1'b0) begin
          bad++;
          $display("FAIL excess_early_fail%0d: got %b want 0", a, bus.tx_fail);
        end
        exp_at = ab + backoff_gap(a, lfsr_prev) + IFG + 1;
      end else begin
        total++;
        if (bus.tx_fail !== 1'b1 || bus.tx_abort !== 1'b1 || bus.tx_late !== 1'b0 || bus.tx_ok !== 1'b0) begin
          bad++;
          $display("FAIL excess_final: got fail=%b abort=%b late=%b ok=%b want 1 1 0 0",
                   bus.tx_fail, bus.tx_abort, bus.tx_late, bus.tx_ok);
        end
      end
    end
    bus.tx_req = 1'b0;
    nstart = 0;
    repeat (400) begin
      tick();
      if (bus.tx_start === 1'b1) nstart++;
    end
    total++;
    if (nstart !== 0 || bus.attempts !== 5'd16) begin
      bad++;
      $display("FAIL excess_after: got starts=%0d att=%0d want 0 16", nstart, bus.attempts);
    end
  endtask

  task automatic test_late();
    int t, ab, fj, nj, nstart;
    do_reset();
    bus.tx_req = 1'b1;
    wait_start(40, t);
    while (cyc < t + 200) tick();
    col = 1'b1;
    tick();
    col = 1'b0;
    wait_abort(40, ab, fj, nj);
    total++;
    if (nj !== JAM || ab !== t + 211) begin
      bad++;
      $display("FAIL late_jam: got len=%0d abort=%0d want len=%0d abort=211", nj, ab - t, JAM);
    end
    total++;
    if (bus.tx_fail !== 1'b1 || bus.tx_late !== 1'b1 || bus.tx_ok !== 1'b0 || bus.attempts !== 5'd1) begin
      bad++;
      $display("FAIL late_status: got fail=%b late=%b ok=%b att=%0d want 1 1 0 1",
               bus.tx_fail, bus.tx_late, bus.tx_ok, bus.attempts);
    end
    bus.tx_req = 1'b0;
    nstart = 0;
    repeat (400) begin
      tick();
      if (bus.tx_start === 1'b1) nstart++;
    end
    total++;
    if (nstart !== 0) begin
      bad++;
      $display("FAIL late_no_retry: got starts=%0d want 0", nstart);
    end
  endtask

  task automatic test_done_wins();
    int t, njam;
    do_reset();
    bus.tx_req = 1'b1;
    wait_start(40, t);
    while (cyc < t + 10) tick();
    col = 1'b1;
    tick();
    col = 1'b0;
    tick();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    total++;
    if (bus.tx_ok !== 1'b1 || bus.tx_jam !== 1'b0) begin
      bad++;
      $display("FAIL done_wins: got ok=%b jam=%b want 1 0", bus.tx_ok, bus.tx_jam);
    end
    bus.tx_req = 1'b0;
    njam = 0;
    repeat (15) begin
      tick();
      if (bus.tx_jam === 1'b1 || bus.tx_abort === 1'b1) njam++;
    end
    total++;
    if (njam !== 0 || bus.attempts !== 5'd0) begin
      bad++;
      $display("FAIL done_wins_after: got jam_cycles=%0d att=%0d want 0 0", njam, bus.attempts);
    end
  endtask

  task automatic test_reset_mid();
    int t, base, at;
    logic [10:0] outs;
    do_reset();
    bus.tx_req = 1'b1;
    wait_start(40, t);
    while (cyc < t + 20) tick();
    col = 1'b1;
    tick();
    col = 1'b0;
    while (cyc < t + 26) tick();
    total++;
    if (bus.tx_jam !== 1'b1) begin
      bad++;
      $display("FAIL mid_in_jam: got %b want 1", bus.tx_jam);
    end
    rst_n = 1'b0;
    tick();
    outs = {bus.tx_start, bus.tx_jam, bus.tx_abort, bus.tx_ok, bus.tx_fail, bus.tx_late, bus.attempts};
    total++;
    if (outs !== 11'd0) begin
      bad++;
      $display("FAIL mid_reset_outputs: got %b want %b", outs, 11'd0);
    end
    rst_n = 1'b1;
    base = cyc + 1;
    wait_start(40, at);
    total++;
    if (at !== base + 25) begin
      bad++;
      $display("FAIL mid_clean_start: got cycle %0d want 25", at - base);
    end
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    bus.tx_req = 1'b0;
    total++;
    if (bus.tx_ok !== 1'b1 || bus.attempts !== 5'd0) begin
      bad++;
      $display("FAIL mid_clean_ok: got ok=%b att=%0d want 1 0", bus.tx_ok, bus.attempts);
    end
    tick();
  endtask

  initial begin
    bus.tx_req  = 1'b0;
    bus.tx_done = 1'b0;
    test_reset();
    test_clean_send();
    test_deferral();
    test_collision();
    test_excess();
    test_late();
    test_done_wins();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mii_tx_ctrl.md
# mii_tx_ctrl

Half-duplex CSMA/CD transmit sequencer for the MII transmit path. It sits between the MAC client and the MII transmitter and decides when a frame may start. It enforces carrier deferral and the inter-frame gap, detects collisions from `col`, orders the jam sequence, and runs truncated binary exponential backoff before retrying. All logic runs in the `txc` domain, one cycle per nibble.

## Interface
- `SLOT_NIBBLES`, 128, slot time in `txc` cycles (512 bit times)
- `IFG_NIBBLES`, 24, inter-frame gap in cycles (96 bit times)
- `JAM_NIBBLES`, 8, jam length in cycles (32 bit times)
- `MAX_ATTEMPTS`, 16, transmission attempts before giving up
- `BACKOFF_LIMIT`, 10, cap on backoff exponent k

Ports:
- `txc`  in  1  transmit clock; the only clock
- `rst_n`  in  1  reset; synchronous, active-low
- `crs`  in  1  carrier sense from PHY; asynchronous
- `col`  in  1  collision detect from PHY; asynchronous
- `tx_req`  in  1  client has a frame; held high until `tx_ok`/`tx_fail`
- `tx_done`  in  1  transmitter pulse: last frame nibble sent
- `tx_start`  out  1  one-cycle pulse: transmitter begins preamble
- `tx_jam`  out  1  level: transmitter drives jam nibble `JAM_NIBBLE`
- `tx_abort`  out  1  one-cycle pulse: transmitter drops `txen`, discards frame
- `tx_ok`  out  1  one-cycle pulse: frame sent
- `tx_fail`  out  1  one-cycle pulse: frame dropped (excess or late collision)
- `tx_late`  out  1  one-cycle pulse with `tx_fail` on late collision
- `attempts`  out  5  collisions for the current frame

## Operation
- `crs` and `col` pass through 2-flop synchronizers, giving `crs_s` and `col_s`. All rules below use the synchronized values.
- FSM states: IDLE, IFG, XMIT, JAM, BACKOFF.
- **IDLE**
  - If `tx_req`=1: `attempts`←0, ifg_cnt←0, go to IFG.
  - `tx_req` is sampled only in IDLE. Dropping it elsewhere has no effect.
- **IFG**
  - ifg_cnt increments on each cycle with `crs_s`=0.
  - `crs_s`=1 clears ifg_cnt to 0.
  - When ifg_cnt reaches `IFG_NIBBLES`: go to XMIT, pulse `tx_start`, slot_cnt←0.
- **XMIT**
  - slot_cnt increments and saturates at `SLOT_NIBBLES`.
  - `tx_done`: pulse `tx_ok`, go to IDLE. `tx_done` wins over a simultaneous `col_s`.
  - `col_s` with slot_cnt < `SLOT_NIBBLES`: normal collision; go to JAM.
  - `col_s` with slot_cnt = `SLOT_NIBBLES`: late collision; set late flag, go to JAM.
- **JAM**
  - `tx_jam`=1 for exactly `JAM_NIBBLES` cycles.
  - On the last jam cycle: pulse `tx_abort`, `attempts`++.
  - Late flag set: pulse `tx_fail` and `tx_late`, go to IDLE.
  - Else if `attempts`=`MAX_ATTEMPTS`: pulse `tx_fail`, go to IDLE.
  - Else: go to BACKOFF with r = lfsr[9:0] & ((1<<k)-1), where k = min(`attempts`, `BACKOFF_LIMIT`).
- **BACKOFF**
  - Wait r×`SLOT_NIBBLES` cycles; r=0 means exactly one cycle.
  - `crs_s`/`col_s` are ignored during BACKOFF.
  - Then ifg_cnt←0, go to IFG.
- LFSR:
  - 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1.
  - Reset seed 16'hACE1; steps every cycle, never zero.
  - r is sampled in the cycle JAM exits.
- `attempts` holds its value after `tx_ok`/`tx_fail` until the next frame is accepted.

## Timing
- Reset (`rst_n`=0 at a `txc` edge):
  - state IDLE; all counters, late flag and `attempts` = 0; all outputs 0; LFSR = seed; synchronizers cleared.
  - Reset mid-XMIT/JAM emits no `tx_abort`; the transmitter shares `rst_n`.
- All outputs are registered.
- `tx_req` sampled at edge 0 with `crs_s`=0 throughout: `tx_start` is high in cycle `IFG_NIBBLES`+1 (cycle 25 by default).
- `col` pin to JAM entry: 3 cycles (2 synchronizer + 1 FSM).
- `tx_done` in cycle n gives `tx_ok` in cycle n+1.
- `tx_jam` falls in the same cycle `tx_abort` pulses.
- `tx_ok` and `tx_fail` are never both high. Exactly one of them pulses per accepted request.

## Structure
- Package `mii_pkg`:
  - state enum
  - `JAM_NIBBLE` = 4'h5
  - default slot/IFG/jam/attempt constants
  - LFSR seed and taps
- Sub-module `mii_backoff_lfsr`: free-running LFSR plus k-bit mask. Inputs `attempts` and a sample strobe; output r.
- Synchronizers and FSM stay in `mii_tx_ctrl`.

## Test plan
- **Clean send.** Reset, `tx_req`=1, `crs`=0 → `tx_start` in cycle 25. `tx_done` at cycle 100 → `tx_ok` at 101, `attempts`=0.
- **Deferral.** `crs_s` high for 5 cycles from IFG cycle 10 → ifg_cnt restarts; `tx_start` 15 cycles later than the clean case.
- **Normal collision.** `col` 20 cycles after `tx_start` → `tx_jam` 8 cycles, then `tx_abort`, `attempts`=1. Force LFSR so r=1 → `tx_start` after 128 + 1 + 24 cycles.
- **Excess collisions.** Collide on every attempt → 16th jam ends with `tx_abort`+`tx_fail`, `attempts`=16, no further `tx_start`.
- **Late collision.** `col` at slot_cnt 200 → jam 8 cycles, then `tx_abort`, `tx_fail`, `tx_late`; no retry.
- **Reset mid-operation.** `rst_n`=0 during JAM cycle 4 → next edge all outputs 0, `tx_jam`=0, IDLE. A new `tx_req` behaves as a clean send.
